// File: rtl/clk_count_pkg.sv
// Shared types, defaults and the wrap/saturate next-count helper for the
// multi-channel gate counter.
package clk_count_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CH    = 2;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  // Values are carried in 32 bits so one helper serves every WIDTH; top is
  // the all-ones value for the caller's width.
  function automatic logic [31:0] count_next(input logic [31:0] cur,
                                             input logic [31:0] top,
                                             input logic        saturate);
    if (cur != top) return cur + 32'd1;
    return saturate ? top : 32'd0;
  endfunction

endpackage

// File: rtl/clk_count_chan.sv
// One gate-counter channel: IDLE/RUN FSM, running counter, captured result
// and the valid/ack handshake with sticky overrun.
module clk_count_chan
  import clk_count_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick,
  input  logic             start,
  input  logic             ack,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] live,
  output logic             valid,
  output logic             ovf,
  output logic             overrun
);

  localparam logic [31:0] TOP = 32'hFFFF_FFFF >> (32 - WIDTH);

  state_t      state;
  logic        ovf_run;
  logic [31:0] cur_ext;
  logic [31:0] nxt;
  logic        at_top;

  always_comb begin
    cur_ext = '0;
    cur_ext[WIDTH-1:0] = live;
  end

  assign nxt    = count_next(cur_ext, TOP, SATURATE != 0);
  assign at_top = (cur_ext == TOP);

  if (WIDTH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^nxt[31:WIDTH];
  end

  // A capture is written after the ack clear so it wins when both land on
  // the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      live    <= '0;
      result  <= '0;
      valid   <= 1'b0;
      ovf     <= 1'b0;
      overrun <= 1'b0;
      ovf_run <= 1'b0;
    end else begin
      if (ack && valid) valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            live  <= WIDTH'(1);
          end
        end
        RUN: begin
          if (start) begin
            if (tick) begin
              live <= nxt[WIDTH-1:0];
              if (at_top) ovf_run <= 1'b1;
            end
          end else begin
            result  <= live;
            ovf     <= ovf_run;
            valid   <= 1'b1;
            live    <= '0;
            ovf_run <= 1'b0;
            state   <= IDLE;
            if (valid && !ack) overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/clk_count_multi.sv
// Multi-channel gate counter top: CH independent channels plus an optional
// shared prescaler enabled by defining CLK_COUNT_PRESCALE_EN.
module clk_count_multi
  import clk_count_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int CH       = DEFAULT_CH,
  parameter int SATURATE = 0,
  parameter int DIV      = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CH-1:0]       start,
  input  logic [CH-1:0]       ack,
  output logic [CH*WIDTH-1:0] Time,
  output logic [CH*WIDTH-1:0] live,
  output logic [CH-1:0]       valid,
  output logic [CH-1:0]       ovf,
  output logic [CH-1:0]       overrun
);

  logic tick;

`ifdef CLK_COUNT_PRESCALE_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_cnt;

  // Free-running across all channels; only reset restarts its phase.
  always_ff @(posedge CLK) begin
    if (RST)                  pre_cnt <= '0;
    else if (pre_cnt == LAST) pre_cnt <= '0;
    else                      pre_cnt <= pre_cnt + PW'(1);
  end

  assign tick = (pre_cnt == LAST);
`else
  localparam int unused_div = DIV;
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_chan
    clk_count_chan #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_chan (
      .CLK     (CLK),
      .RST     (RST),
      .tick    (tick),
      .start   (start[i]),
      .ack     (ack[i]),
      .result  (Time[i*WIDTH +: WIDTH]),
      .live    (live[i*WIDTH +: WIDTH]),
      .valid   (valid[i]),
      .ovf     (ovf[i]),
      .overrun (overrun[i])
    );
  end

endmodule

// File: tb/tb_clk_count_multi.sv
// Self-checking bench: a wrap and a saturate instance share random and
// directed stimulus and are compared every cycle against a count-based model.
module tb_clk_count_multi;

  localparam int W     = 4;
  localparam int NCH   = 2;
  localparam int DIV_P = 3;
  localparam int TOP   = (1 << W) - 1;

  logic             CLK;
  logic             RST;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   ack;
  logic [NCH*W-1:0] Time_w, live_w, Time_s, live_s;
  logic [NCH-1:0]   valid_w, ovf_w, overrun_w, valid_s, ovf_s, overrun_s;

  int tests;
  int failures;

  // Model: count of increments per channel; the output value is derived
  // from that count according to wrap or saturate rules.
  bit run_m  [NCH];
  int n_m    [NCH];
  int cap_m  [NCH];
  bit valid_m[NCH];
  bit ovf_m  [NCH];
  bit over_m [NCH];
  int phase_m;

  clk_count_multi #(.WIDTH(W), .CH(NCH), .SATURATE(0), .DIV(DIV_P)) dut_wrap (
    .CLK(CLK), .RST(RST), .start(start), .ack(ack),
    .Time(Time_w), .live(live_w), .valid(valid_w), .ovf(ovf_w), .overrun(overrun_w)
  );

  clk_count_multi #(.WIDTH(W), .CH(NCH), .SATURATE(1), .DIV(DIV_P)) dut_sat (
    .CLK(CLK), .RST(RST), .start(start), .ack(ack),
    .Time(Time_s), .live(live_s), .valid(valid_s), .ovf(ovf_s), .overrun(overrun_s)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic int mapCount(input int n, input bit sat);
    if (sat) return (n > TOP) ? TOP : n;
    return n % (TOP + 1);
  endfunction

  function automatic bit modelTick();
`ifdef CLK_COUNT_PRESCALE_EN
    return (phase_m == DIV_P - 1);
`else
    return 1'b1;
`endif
  endfunction

  task automatic modelStep();
    bit tk;
    bit v_old;
    tk = modelTick();
    if (RST) begin
      phase_m = 0;
      for (int i = 0; i < NCH; i++) begin
        run_m[i] = 0; n_m[i] = 0; cap_m[i] = 0;
        valid_m[i] = 0; ovf_m[i] = 0; over_m[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        v_old = valid_m[i];
        if (ack[i] && v_old) valid_m[i] = 0;
        if (run_m[i]) begin
          if (start[i]) begin
            if (tk) n_m[i]++;
          end else begin
            if (v_old && !ack[i]) over_m[i] = 1;
            cap_m[i]   = n_m[i];
            ovf_m[i]   = (n_m[i] > TOP);
            valid_m[i] = 1;
            run_m[i]   = 0;
            n_m[i]     = 0;
          end
        end else if (start[i]) begin
          run_m[i] = 1;
          n_m[i]   = 1;
        end
      end
      phase_m = (phase_m + 1) % DIV_P;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [NCH*W-1:0] et_w, et_s, el_w, el_s;
    logic [NCH-1:0]   ev, eo, er;
    for (int i = 0; i < NCH; i++) begin
      et_w[i*W +: W] = W'(mapCount(cap_m[i], 1'b0));
      et_s[i*W +: W] = W'(mapCount(cap_m[i], 1'b1));
      el_w[i*W +: W] = run_m[i] ? W'(mapCount(n_m[i], 1'b0)) : W'(0);
      el_s[i*W +: W] = run_m[i] ? W'(mapCount(n_m[i], 1'b1)) : W'(0);
      ev[i] = valid_m[i];
      eo[i] = ovf_m[i];
      er[i] = over_m[i];
    end
    check("wrap.Time",    64'(Time_w),    64'(et_w));
    check("wrap.live",    64'(live_w),    64'(el_w));
    check("wrap.valid",   64'(valid_w),   64'(ev));
    check("wrap.ovf",     64'(ovf_w),     64'(eo));
    check("wrap.overrun", 64'(overrun_w), 64'(er));
    check("sat.Time",     64'(Time_s),    64'(et_s));
    check("sat.live",     64'(live_s),    64'(el_s));
    check("sat.valid",    64'(valid_s),   64'(ev));
    check("sat.ovf",      64'(ovf_s),     64'(eo));
    check("sat.overrun",  64'(overrun_s), 64'(er));
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] s, input logic [NCH-1:0] a, input logic r);
    start = s;
    ack   = a;
    RST   = r;
    @(posedge CLK);
    modelStep();
    @(negedge CLK);
    checkOutput();
  endtask

  initial begin
    logic [NCH-1:0] s;
    logic [NCH-1:0] a;
    logic           r;
    tests    = 0;
    failures = 0;
    RST      = 1'b1;
    start    = '1;
    ack      = '0;
    phase_m  = 0;

    repeat (2) applyStimulus(2'b11, 2'b00, 1'b1);
    check("lit.reset.Time",  64'(Time_w),    64'h0);
    check("lit.reset.live",  64'(live_w),    64'h0);
    check("lit.reset.valid", 64'(valid_w),   64'h0);
    check("lit.reset.ovr",   64'(overrun_s), 64'h0);

    applyStimulus(2'b11, 2'b00, 1'b0);
    check("lit.first.live", 64'(live_w), 64'h11);

`ifndef CLK_COUNT_PRESCALE_EN
    repeat (4) applyStimulus(2'b11, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    check("lit.cap5.Time",  64'(Time_w),  64'h55);
    check("lit.cap5.valid", 64'(valid_w), 64'h3);

    applyStimulus(2'b00, 2'b01, 1'b0);
    check("lit.ack.valid", 64'(valid_w), 64'h2);
    check("lit.ack.Time",  64'(Time_w),  64'h55);

    repeat (18) applyStimulus(2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    check("lit.wrap.Time", 64'(Time_w), 64'h52);
    check("lit.sat.Time",  64'(Time_s), 64'h5f);
    check("lit.wrap.ovf",  64'(ovf_w),  64'h1);
    check("lit.sat.ovf",   64'(ovf_s),  64'h1);

    repeat (3) applyStimulus(2'b01, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b00, 1'b0);
    check("lit.ovr.Time",    64'(Time_w),    64'h53);
    check("lit.ovr.overrun", 64'(overrun_w), 64'h1);
    check("lit.ovr.ovf",     64'(ovf_w),     64'h0);

    repeat (3) applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b00, 2'b10, 1'b0);
    check("lit.same.Time",    64'(Time_w),    64'h33);
    check("lit.same.valid",   64'(valid_w),   64'h3);
    check("lit.same.overrun", 64'(overrun_w), 64'h1);

    repeat (3) applyStimulus(2'b10, 2'b00, 1'b0);
    applyStimulus(2'b10, 2'b00, 1'b1);
    check("lit.midrst.live",  64'(live_w),  64'h0);
    check("lit.midrst.valid", 64'(valid_w), 64'h0);
    check("lit.midrst.Time",  64'(Time_w),  64'h0);
    applyStimulus(2'b10, 2'b00, 1'b0);
    check("lit.restart.live", 64'(live_w), 64'h10);
`endif

    s = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(7) == 0) s[i] = ~s[i];
        a[i] = ($urandom_range(5) == 0);
      end
      r = ($urandom_range(299) == 0);
      applyStimulus(s, a, r);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
